cordic_vector: RTL and testbench

CORDIC_VECTOR -- requirements
Module: cordic_vector

---
 rtl/cordic_pkg.sv | 21 ++
 rtl/cordic_vector_stage.sv | 50 +++++
 rtl/cordic_vector.sv | 115 +++++++++++
 tb/tb_cordic_vector.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: stage count, Q2.14 angle/gain constants and the
// arctangent table used by both the vectoring and rotation-mode CORDIC blocks.
package cordic_pkg;

    localparam int NTAB = 16;
    localparam int XYW  = 18;  // internal x/y width: headroom for negation and gain
    localparam int ZW   = 32;  // angle accumulator width, matches angle_out

    localparam logic signed [ZW-1:0] PI        = 32'sh0000_C90F;
    localparam logic signed [ZW-1:0] HALF_PI   = 32'sh0000_6488;
    localparam logic        [15:0]   CORDIC_1K = 16'h26DD;

    // atan(2^-k) in Q2.14, truncated
    localparam logic [15:0] ATAN [NTAB] = '{
        16'h3243, 16'h1DAC, 16'h0FAD, 16'h07F5,
        16'h03FE, 16'h01FF, 16'h00FF, 16'h007F,
        16'h003F, 16'h001F, 16'h000F, 16'h0007,
        16'h0003, 16'h0001, 16'h0000, 16'h0000
    };

endpackage

// File: rtl/cordic_vector_stage.sv
// One registered vectoring micro-rotation: drives y toward zero by +/-atan(2^-k)
// and accumulates the applied rotation in z.
module cordic_vector_stage
    import cordic_pkg::*;
#(
    parameter int          SHIFT  = 0,
    parameter logic [15:0] ATAN_K = 16'h0000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic signed [XYW-1:0] x,
    input  logic signed [XYW-1:0] y,
    input  logic signed [ZW-1:0]  z,
    input  logic                  valid,
    output logic signed [XYW-1:0] x_next,
    output logic signed [XYW-1:0] y_next,
    output logic signed [ZW-1:0]  z_next,
    output logic                  valid_next
);

    localparam logic signed [ZW-1:0] ATAN_Z = $signed({{(ZW-16){1'b0}}, ATAN_K});

    logic signed [XYW-1:0] x_sh;
    logic signed [XYW-1:0] y_sh;

    assign x_sh = x >>> SHIFT;
    assign y_sh = y >>> SHIFT;

    // NOTE: non-blocking assignments so every stage samples its neighbour's pre-edge value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_next     <= '0;
            y_next     <= '0;
            z_next     <= '0;
            valid_next <= 1'b0;
        end else begin
            valid_next <= valid;
            if (!y[XYW-1]) begin
                x_next <= x + y_sh;
                y_next <= y - x_sh;
                z_next <= z + ATAN_Z;
            end else begin
                x_next <= x - y_sh;
                y_next <= y + x_sh;
                z_next <= z - ATAN_Z;
            end
        end
    end

endmodule

// File: rtl/cordic_vector.sv
// Fully pipelined vectoring CORDIC: atan2(y,x) and gain-compensated magnitude,
// one sample per cycle, 18-cycle latency (pre-rotation, NTAB stages, output).
module cordic_vector
    import cordic_pkg::*;
#(
    parameter int NTAB = cordic_pkg::NTAB
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] x_in,
    input  logic [15:0] y_in,
    input  logic        valid_in,
    output logic [31:0] angle_out,
    output logic [15:0] mag_out,
    output logic        valid_out
);

    localparam int PW = XYW + 17;
    localparam logic signed [16:0] MAG_K = {1'b0, CORDIC_1K};

    logic signed [XYW-1:0] xs [NTAB+1];
    logic signed [XYW-1:0] ys [NTAB+1];
    logic signed [ZW-1:0]  zs [NTAB+1];
    logic                  vs [NTAB+1];

    logic signed [XYW-1:0] x_ext, y_ext, x0, y0;
    logic signed [ZW-1:0]  z0;
    logic                  v0;

    assign x_ext = {{(XYW-16){x_in[15]}}, x_in};
    assign y_ext = {{(XYW-16){y_in[15]}}, y_in};

    // Left half-plane inputs are rotated by PI so the stages only see x >= 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x0 <= '0;
            y0 <= '0;
            z0 <= '0;
            v0 <= 1'b0;
        end else begin
            v0 <= valid_in;
            if (x_in[15]) begin
                x0 <= -x_ext;
                y0 <= -y_ext;
                z0 <= y_in[15] ? -PI : PI;
            end else begin
                x0 <= x_ext;
                y0 <= y_ext;
                z0 <= '0;
            end
        end
    end

    assign xs[0] = x0;
    assign ys[0] = y0;
    assign zs[0] = z0;
    assign vs[0] = v0;

    for (genvar k = 0; k < NTAB; k++) begin : g_stage
        cordic_vector_stage #(
            .SHIFT  (k),
            .ATAN_K (ATAN[k])
        ) u_stage (
            .clock      (clock),
            .reset      (reset),
            .x          (xs[k]),
            .y          (ys[k]),
            .z          (zs[k]),
            .valid      (vs[k]),
            .x_next     (xs[k+1]),
            .y_next     (ys[k+1]),
            .z_next     (zs[k+1]),
            .valid_next (vs[k+1])
        );
    end

    logic signed [PW-1:0] prod;
    logic        [15:0]   mag_sat;
    logic signed [ZW-1:0] angle_sel;

    assign prod = PW'(xs[NTAB]) * PW'(MAG_K);

    // x_final is zero only for a zero input vector, whose angle is defined as 0.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        mag_sat = prod[29:14];
        if (prod[PW-1]) begin
            mag_sat = '0;
        end else if (|prod[PW-2:30]) begin
            mag_sat = 16'hFFFF;
        end

        angle_sel = zs[NTAB];
        if (xs[NTAB] == '0) begin
            angle_sel = '0;
        end else if (zs[NTAB] > PI) begin
            angle_sel = PI;
        end else if (zs[NTAB] < -PI) begin
            angle_sel = -PI;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            angle_out <= '0;
            mag_out   <= '0;
            valid_out <= 1'b0;
        end else begin
            angle_out <= angle_sel;
            mag_out   <= mag_sat;
            valid_out <= vs[NTAB];
        end
    end

endmodule

// File: tb/tb_cordic_vector.sv
// Scoreboard bench for cordic_vector: a behavioural CORDIC model predicts each
// result at drive time; a negedge monitor pops and compares results and latency.
module tb_cordic_vector;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] x_in = '0;
    logic [15:0] y_in = '0;
    logic        valid_in = 1'b0;
    logic [31:0] angle_out;
    logic [15:0] mag_out;
    logic        valid_out;

    cordic_vector dut (
        .clock     (clock),
        .reset     (reset),
        .x_in      (x_in),
        .y_in      (y_in),
        .valid_in  (valid_in),
        .angle_out (angle_out),
        .mag_out   (mag_out),
        .valid_out (valid_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        longint m_ang;
        longint m_mag;
        bit     spec;
        longint s_ang;
        longint s_mag;
        longint tol;
        longint due;
    } exp_t;

    localparam int     TAB [16] = '{12867, 7596, 4013, 2037, 1022, 511, 255, 127,
                                    63, 31, 15, 7, 3, 1, 0, 0};
    localparam longint PI_Q = 51471;
    localparam int     LAT  = 18;

    exp_t   sb [$];
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    bit     mon_en = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint want,
                         input longint tol);
        checks++;
        if (got > want + tol || got < want - tol) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (tol %0d) cycle %0d", tag, got, want, tol, cyc);
        end
    endtask

    function automatic void model(input logic [15:0] xi, input logic [15:0] yi,
                                  output longint ang, output longint mag);
        longint x, y, z, xn, yn, p;
        x = longint'($signed(xi));
        y = longint'($signed(yi));
        z = 0;
        if (x < 0) begin
            z = (y < 0) ? -PI_Q : PI_Q;
            x = -x;
            y = -y;
        end
        for (int k = 0; k < 16; k++) begin
            if (y >= 0) begin
                xn = x + (y >>> k);
                yn = y - (x >>> k);
                z  = z + TAB[k];
            end else begin
                xn = x - (y >>> k);
                yn = y + (x >>> k);
                z  = z - TAB[k];
            end
            x = xn;
            y = yn;
        end
        p = (x * 9949) >>> 14;
        if (p > 65535) p = 65535;
        if (p < 0) p = 0;
        mag = p;
        if (xi == 16'h0000 && yi == 16'h0000) ang = 0;
        else if (z > PI_Q) ang = PI_Q;
        else if (z < -PI_Q) ang = -PI_Q;
        else ang = z;
    endfunction

    task automatic drive(input logic [15:0] xv, input logic [15:0] yv, input bit v,
                         input bit spec, input longint sa, input longint sm,
                         input longint tol);
        exp_t   e;
        longint ma, mm;
        @(negedge clock);
        x_in     = xv;
        y_in     = yv;
        valid_in = v;
        if (v) begin
            model(xv, yv, ma, mm);
            e.m_ang = ma;
            e.m_mag = mm;
            e.spec  = spec;
            e.s_ang = sa;
            e.s_mag = sm;
            e.tol   = tol;
            e.due   = cyc + LAT;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(16'($urandom()), 16'($urandom()), 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic drain();
        int n = 0;
        idle(1);
        while (sb.size() > 0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("drain_empty", longint'(sb.size()), 0, 0);
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            if (valid_out) begin
                if (sb.size() == 0) begin
                    check("extra_valid", longint'(valid_out), 0, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("latency", cyc, e.due, 0);
                    check("angle_model", longint'($signed(angle_out)), e.m_ang, 0);
                    check("mag_model", longint'(mag_out), e.m_mag, 0);
                    if (e.spec) begin
                        check("angle_spec", longint'($signed(angle_out)), e.s_ang, e.tol);
                        check("mag_spec", longint'(mag_out), e.s_mag, e.tol);
                    end
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                check("missing_valid", longint'(valid_out), 1, 0);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("reset_valid", longint'(valid_out), 0, 0);
        check("reset_angle", longint'(angle_out), 0, 0);
        check("reset_mag", longint'(mag_out), 0, 0);
        @(negedge clock);
        reset  = 1'b1;
        mon_en = 1'b1;

        // Directed vectors on the axes, diagonals and the branch cut.
        drive(16'h4000, 16'h0000, 1'b1, 1'b1, 0, 16384, 4);
        drive(16'h0000, 16'h4000, 1'b1, 1'b1, 25736, 16384, 4);
        drive(16'h0000, 16'hC000, 1'b1, 1'b1, -25736, 16384, 4);
        drive(16'hC000, 16'h0000, 1'b1, 1'b1, 51471, 16384, 4);
        drive(16'h8000, 16'h8000, 1'b1, 1'b1, -38603, 46341, 4);
        drive(16'h4000, 16'h4000, 1'b1, 1'b1, 12868, 23170, 4);
        drive(16'h0000, 16'h0000, 1'b1, 1'b1, 0, 0, 0);
        drive(16'h8000, 16'h0000, 1'b1, 1'b1, 51471, 32768, 4);
        drive(16'h7FFF, 16'h8000, 1'b1, 1'b0, 0, 0, 0);
        drain();

        for (int i = 0; i < 64; i++)
            drive(16'($urandom()), 16'($urandom()), 1'b1, 1'b0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            drive(16'($urandom()), 16'($urandom()), (i % 2) == 0, 1'b0, 0, 0, 0);
        drain();

        // Reset with ten samples in flight: all must vanish.
        for (int i = 0; i < 10; i++)
            drive(16'($urandom()), 16'($urandom()), 1'b1, 1'b0, 0, 0, 0);
        idle(3);
        @(posedge clock);
        #2;
        reset = 1'b0;
        sb.delete();
        #1;
        check("rst_flight_valid", longint'(valid_out), 0, 0);
        check("rst_flight_angle", longint'(angle_out), 0, 0);
        check("rst_flight_mag", longint'(mag_out), 0, 0);
        @(posedge clock);
        #2;
        reset = 1'b1;
        idle(25);
        drive(16'h0000, 16'h4000, 1'b1, 1'b1, 25736, 16384, 4);
        drain();
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
